spi_register_controller: RTL and testbench
==========================================

Name: spi_register_controller

Overview:
- SPI-slave front end that configures the synth core: receives register-write frames from the host MCU, buffers them in a small FIFO and issues single-cycle register writes (number + value) on the core's write port.
- Returns a status byte (FIFO fill level and a sticky overflow flag) on MISO during the first byte of every frame.
- Runs entirely in the i_Clock domain. SPI pins are oversampled, and i_Clock must be at least 8x SCLK.

Parameters:
- FIFO_DEPTH, 4, number of buffered write frames (2..31).
- SYNC_STAGES, 2, synchronizer flops on i_SCLK, i_CS_N and i_MOSI (>=2).

Ports:
- i_Clock  in  1  system clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_SCLK  in  1  SPI clock; mode 0 (CPOL=0, CPHA=0).
- i_CS_N  in  1  SPI chip select, active low.
- i_MOSI  in  1  SPI data in, MSB first.
- o_MISO  out  1  SPI data out, MSB first.
- i_WriteReady  in  1  core can accept a write this cycle; synth ties it high.
- o_RegisterWriteEnable  out  1  one-cycle write strobe to the core.
- o_RegisterNumber  out  16  register address for the strobe.
- o_RegisterValue  out  8  register data for the strobe.
- o_FifoCount  out  5  current FIFO occupancy.
- o_Overflow  out  1  sticky flag: a frame was dropped because the FIFO was full.

Behaviour:
- Reset: all outputs 0; FIFO empty; bit counter 0; o_Overflow 0; state IDLE. Reset mid-frame discards the partial frame. After reset, no frame is accepted until i_CS_N has been seen high for at least one synchronized sample.
- Synchronization: i_SCLK, i_CS_N and i_MOSI each pass through SYNC_STAGES flops. Rise and fall of SCLK are detected against one further registered copy.
- State machine:
  - IDLE: wait for synchronized CS_N = 0. On entry to SELECTED, clear the bit counter and load the status byte into the MISO shift register.
  - SELECTED: on each SCLK rise, shift MOSI into a 24-bit shift register and increment a 5-bit counter.
    - On each SCLK fall, shift MISO left (fill 0).
    - On the rise that brings the count to 24, commit the frame and reset the counter to 0. Frame layout: bits[23:8] = register number, bits[7:0] = value.
    - Streaming: further frames are allowed in the same CS_N assertion. Each new frame reloads the status byte at the rise that completed the previous frame.
    - CS_N high while count != 0: the partial frame is discarded and no write occurs. Return to IDLE.
- Status byte = {o_Overflow, 2'b00, o_FifoCount}, sampled at load time. Bytes 2 and 3 of each frame drive MISO = 0.
- o_MISO = MSB of the MISO shift register; 0 in IDLE.
- Commit:
  - FIFO not full: push the frame.
  - FIFO full: drop the frame and set o_Overflow.
  - Push while a pop happens in the same cycle on a full FIFO is accepted (no drop).
- Overflow clear: o_Overflow clears on the 8th SCLK rise of a frame (status byte fully shifted out). If a set and a clear occur in the same cycle, set wins.
- Output stage:
  - When the FIFO is non-empty and i_WriteReady = 1, pop one entry and register it onto o_RegisterNumber/o_RegisterValue with o_RegisterWriteEnable = 1 for exactly one cycle.
  - At most one write per cycle. Number and value hold their last values when the strobe is 0.
- Latency: let E0 be the first i_Clock edge at which i_SCLK samples high for the 24th bit. With SYNC_STAGES = 2, an empty FIFO and ready high, the push happens at E0+2 and o_RegisterWriteEnable is high in the cycle after E0+3.
- i_WriteReady low: entries are held in order and nothing is lost; the next entry is issued on the first cycle ready returns high.
- o_FifoCount reflects pushes and pops registered at the same edge. A simultaneous push and pop leaves the count unchanged.

Test Plan:
- Reset, then one frame 0xC005_80 (SCLK = clk/8) -> exactly one strobe with number 0xC005, value 0x80, high in the cycle after E0+3; o_FifoCount returns to 0.
- Three frames streamed in one CS_N assertion: 0x8000_01, 0x8001_07, 0xC100_40 -> three strobes in the same order with matching fields; MISO reads status 0x00 at the start of each frame.
- i_WriteReady = 0, send 5 frames with FIFO_DEPTH = 4 -> o_FifoCount = 4, o_Overflow = 1, 5th frame lost. Raise ready -> first 4 frames drain in 4 consecutive cycles.
- After the overflow case, send a frame -> MISO status byte reads 0x80 (overflow set, count 0) and o_Overflow clears on the 8th SCLK rise.
- Deassert CS_N after 13 bits -> no strobe and no FIFO change. The next full frame 0xC200_FF is written correctly.
- Assert i_Reset mid-frame with CS_N held low -> outputs go to 0 and nothing is written until CS_N toggles high then low. A frame sent after that is written normally.

Source files
------------

// File: rtl/spi_register_controller.sv
// SPI-slave register-write front end: oversampled mode-0 SPI, 24-bit write frames
// buffered in a small FIFO and issued as single-cycle register writes to the core.
module spi_register_controller #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_SCLK,
  input  logic        i_CS_N,
  input  logic        i_MOSI,
  output logic        o_MISO,
  input  logic        i_WriteReady,
  output logic        o_RegisterWriteEnable,
  output logic [15:0] o_RegisterNumber,
  output logic [7:0]  o_RegisterValue,
  output logic [4:0]  o_FifoCount,
  output logic        o_Overflow
);

  localparam int unsigned FRAME_W = 24;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] STATUS_END = CNT_W'(7);
  localparam logic [4:0]       DEPTH_CNT  = 5'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic {
    IDLE,
    SELECTED
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   armed;

  logic [CNT_W-1:0]       bit_cnt;
  logic [FRAME_W-2:0]     rx_sr;
  logic [7:0]             miso_sr;
  logic                   hold_shift;
  logic [FRAME_W-1:0]     frame;
  logic [7:0]             status;

  logic                   load_status;
  logic                   shift_in;
  logic                   shift_out;
  logic                   commit;
  logic                   enter_sel;
  logic                   go_idle;

  logic [FRAME_W-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [4:0]             count;
  logic                   overflow;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;
  logic                   drop;
  logic                   ovf_clear;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Pin synchronizers plus one extra SCLK copy for edge detection
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_SCLK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_CS_N};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_MOSI};
      sclk_d    <= sclk_s;
      if (cs_s) begin
        armed <= 1'b1;
      end
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;

  assign frame  = {rx_sr, mosi_s};
  assign status = {overflow, 2'b00, count};

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    load_status = 1'b0;
    shift_in    = 1'b0;
    shift_out   = 1'b0;
    commit      = 1'b0;
    enter_sel   = 1'b0;
    go_idle     = 1'b0;
    case (state)
      IDLE: begin
        if (armed && !cs_s) begin
          state_next  = SELECTED;
          enter_sel   = 1'b1;
          load_status = 1'b1;
        end
      end
      SELECTED: begin
        if (cs_s) begin
          state_next = IDLE;
          go_idle    = 1'b1;
        end else if (sclk_rise) begin
          shift_in = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            commit      = 1'b1;
            load_status = 1'b1;
          end
        end else if (sclk_fall) begin
          shift_out = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        go_idle    = 1'b1;
      end
    endcase
  end

  // A status reload at frame end must survive the trailing SCLK fall of that frame
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      bit_cnt    <= '0;
      rx_sr      <= '0;
      miso_sr    <= '0;
      hold_shift <= 1'b0;
    end else begin
      if (enter_sel || go_idle || commit) begin
        bit_cnt <= '0;
      end else if (shift_in) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end

      if (shift_in) begin
        rx_sr <= frame[FRAME_W-2:0];
      end

      if (load_status) begin
        miso_sr    <= status;
        hold_shift <= commit;
      end else if (go_idle) begin
        miso_sr    <= '0;
        hold_shift <= 1'b0;
      end else if (shift_out) begin
        if (hold_shift) begin
          hold_shift <= 1'b0;
        end else begin
          miso_sr <= {miso_sr[6:0], 1'b0};
        end
      end
    end
  end

  assign o_MISO = miso_sr[7];

  assign fifo_full  = (count == DEPTH_CNT);
  assign fifo_empty = (count == 5'd0);
  assign pop        = ~fifo_empty & i_WriteReady;
  assign push       = commit & (~fifo_full | pop);
  assign drop       = commit & fifo_full & ~pop;
  assign ovf_clear  = shift_in & (bit_cnt == STATUS_END);

  always_ff @(posedge i_Clock) begin
    if (push) begin
      mem[wr_ptr] <= frame;
    end
  end

  // FIFO bookkeeping, sticky overflow (set beats clear) and the write port
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr                <= '0;
      rd_ptr                <= '0;
      count                 <= '0;
      overflow              <= 1'b0;
      o_RegisterWriteEnable <= 1'b0;
      o_RegisterNumber      <= '0;
      o_RegisterValue       <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase

      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clear) begin
        overflow <= 1'b0;
      end

      o_RegisterWriteEnable <= pop;
      if (pop) begin
        o_RegisterNumber <= mem[rd_ptr][23:8];
        o_RegisterValue  <= mem[rd_ptr][7:0];
      end
    end
  end

  assign o_FifoCount = count;
  assign o_Overflow  = overflow;

endmodule

// File: tb/tb_spi_register_controller.sv
// Directed + randomized bench for spi_register_controller against a frame-level
// model: expected writes queue, pending FIFO contents and sticky overflow flag.
module tb_spi_register_controller;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        sclk;
  logic        cs_n;
  logic        mosi;
  logic        miso;
  logic        ready;
  logic        wen;
  logic [15:0] reg_num;
  logic [7:0]  reg_val;
  logic [4:0]  fifo_count;
  logic        overflow;

  spi_register_controller #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .i_Clock              (clk),
    .i_Reset              (rst),
    .i_SCLK               (sclk),
    .i_CS_N               (cs_n),
    .i_MOSI               (mosi),
    .o_MISO               (miso),
    .i_WriteReady         (ready),
    .o_RegisterWriteEnable(wen),
    .o_RegisterNumber     (reg_num),
    .o_RegisterValue      (reg_val),
    .o_FifoCount          (fifo_count),
    .o_Overflow           (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Observed write strobes with the cycle they appeared in
  logic [23:0] obs [$];
  int          obs_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wen === 1'b1) begin
      obs.push_back({reg_num, reg_val});
      obs_cyc.push_back(cyc);
    end
  end

  // Reference model
  logic [23:0] expq [$];
  logic [23:0] pend [$];
  logic        m_ovf = 1'b0;
  int          ck = 0;

  function automatic logic [7:0] m_status();
    return {m_ovf, 2'b00, 5'(pend.size())};
  endfunction

  function automatic void m_commit(input logic [23:0] d);
    if (pend.size() == DEPTH) m_ovf = 1'b1;
    else if (ready) expq.push_back(d);
    else pend.push_back(d);
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
    end
  endtask

  task automatic spi_bit(input logic b, input bit lat, output logic m);
    mosi = b;
    m = miso;
    sclk = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (lat) chk("latency_wen", 32'(wen), 32'(k == 4));
    end
    sclk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [23:0] d, input bit lat, output logic [23:0] m);
    for (int i = 23; i >= 0; i--) spi_bit(d[i], lat && (i == 0), m[i]);
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic model_frame(input logic [23:0] d, input logic [7:0] st, input logic [23:0] m,
                             input string tag);
    chk(tag, 32'(m), 32'({st, 16'h0000}));
    m_ovf = 1'b0;
    m_commit(d);
  endtask

  task automatic cs_frame(input logic [23:0] d, input string tag);
    logic [23:0] m;
    logic [7:0]  st;
    cs_low();
    st = m_status();
    send_frame(d, 1'b0, m);
    model_frame(d, st, m, tag);
    cs_high();
  endtask

  task automatic raise_ready();
    ready = 1'b1;
    while (pend.size() > 0) expq.push_back(pend.pop_front());
  endtask

  task automatic check_writes(input string tag);
    int n = 0;
    while (obs.size() < expq.size() && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    chk({tag, "_count"}, 32'(obs.size()), 32'(expq.size()));
    for (int i = ck; i < expq.size() && i < obs.size(); i++) begin
      chk({tag, "_number"}, 32'(obs[i][23:8]), 32'(expq[i][23:8]));
      chk({tag, "_value"}, 32'(obs[i][7:0]), 32'(expq[i][7:0]));
    end
    ck = expq.size();
  endtask

  initial begin
    logic [23:0] m;
    logic [23:0] d;
    logic [7:0]  st;
    logic [23:0] stream_d [6];
    int          base;
    logic        b;

    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_wen", 32'(wen), 32'd0);
    chk("reset_number", 32'(reg_num), 32'd0);
    chk("reset_value", 32'(reg_val), 32'd0);
    chk("reset_count", 32'(fifo_count), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_miso", 32'(miso), 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Single frame with strobe latency check
    cs_low();
    st = m_status();
    send_frame(24'hC00580, 1'b1, m);
    model_frame(24'hC00580, st, m, "single_miso");
    cs_high();
    check_writes("single");
    chk("single_count_zero", 32'(fifo_count), 32'd0);

    // Streaming: the three fixed frames followed by three random ones in one CS
    stream_d[0] = 24'h800001; stream_d[1] = 24'h800107; stream_d[2] = 24'hC10040;
    for (int i = 3; i < 6; i++) stream_d[i] = 24'($urandom);
    cs_low();
    for (int i = 0; i < 6; i++) begin
      st = m_status();
      send_frame(stream_d[i], 1'b0, m);
      model_frame(stream_d[i], st, m, "stream_miso");
    end
    cs_high();
    check_writes("stream");

    // Overflow: ready low, DEPTH+1 random frames
    ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) cs_frame(24'($urandom), "ovf_miso");
    chk("ovf_count", 32'(fifo_count), 32'(DEPTH));
    chk("ovf_flag", 32'(overflow), 32'd1);
    base = ck;
    raise_ready();
    check_writes("drain");
    for (int i = base + 1; i < base + DEPTH && i < obs_cyc.size(); i++)
      chk("drain_consecutive", 32'(obs_cyc[i] - obs_cyc[i-1]), 32'd1);
    chk("drain_count_zero", 32'(fifo_count), 32'd0);

    // Status byte after overflow; flag clears on the 8th rise
    d = 24'($urandom);
    cs_low();
    st = m_status();
    for (int i = 23; i >= 0; i--) begin
      spi_bit(d[i], 1'b0, b);
      m[i] = b;
      if (i == 17) chk("ovf_before_8th", 32'(overflow), 32'd1);
      if (i == 16) chk("ovf_after_8th", 32'(overflow), 32'd0);
    end
    chk("status_byte", 32'(st), 32'h80);
    model_frame(d, st, m, "status_miso");
    cs_high();
    check_writes("status");

    // Abort after 13 bits, then a normal frame
    d = 24'($urandom);
    cs_low();
    for (int i = 23; i > 10; i--) spi_bit(d[i], 1'b0, b);
    m_ovf = 1'b0;
    cs_high();
    chk("abort_count", 32'(fifo_count), 32'd0);
    check_writes("abort");
    cs_frame(24'hC200FF, "after_abort_miso");
    check_writes("after_abort");

    // Reset mid-frame with CS held low
    ready = 1'b0;
    cs_frame(24'($urandom), "pre_reset_miso");
    chk("pre_reset_count", 32'(fifo_count), 32'd1);
    cs_low();
    d = 24'($urandom);
    for (int i = 23; i > 13; i--) spi_bit(d[i], 1'b0, b);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pend.delete();
    m_ovf = 1'b0;
    chk("midreset_wen", 32'(wen), 32'd0);
    chk("midreset_number", 32'(reg_num), 32'd0);
    chk("midreset_value", 32'(reg_val), 32'd0);
    chk("midreset_count", 32'(fifo_count), 32'd0);
    chk("midreset_overflow", 32'(overflow), 32'd0);
    chk("midreset_miso", 32'(miso), 32'd0);
    ready = 1'b1;
    send_frame(24'($urandom), 1'b0, m);
    chk("unarmed_miso", 32'(m), 32'd0);
    check_writes("unarmed");
    chk("unarmed_count", 32'(fifo_count), 32'd0);
    cs_high();
    cs_frame(24'($urandom), "rearmed_miso");
    check_writes("rearmed");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
